// File: rtl/de_selector_pkg.sv
// Shared select encodings and default idle level for the 1-to-4 data distributor.
package de_selector_pkg;

    localparam logic [1:0] SEL_Z0 = 2'b00;
    localparam logic [1:0] SEL_Z1 = 2'b01;
    localparam logic [1:0] SEL_Z2 = 2'b10;
    localparam logic [1:0] SEL_Z3 = 2'b11;

    localparam logic IDLE_VAL_DEFAULT = 1'b1;

endpackage

// File: rtl/de_selector_14_dec.sv
// Select decoder: turns the {iS1,iS0} pair into a one-hot channel-enable vector.
module de_selector_14_dec
    import de_selector_pkg::*;
(
    input  logic       iS1,
    input  logic       iS0,
    output logic [3:0] en
);

    always_comb begin
        en = '0;
        unique case ({iS1, iS0})
            SEL_Z0:  en = 4'b0001;
            SEL_Z1:  en = 4'b0010;
            SEL_Z2:  en = 4'b0100;
            SEL_Z3:  en = 4'b1000;
            default: en = '0;
        endcase
    end

endmodule

// File: rtl/de_selector_14.sv
// 1-to-4 demultiplexer with registered outputs; unselected channels sit at the idle level.
module de_selector_14
    import de_selector_pkg::*;
#(
    parameter int unsigned DATA_W   = 1,
    parameter logic        IDLE_VAL = IDLE_VAL_DEFAULT
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iC,
    input  logic              iS1,
    input  logic              iS0,
    output logic [DATA_W-1:0] oZ0,
    output logic [DATA_W-1:0] oZ1,
    output logic [DATA_W-1:0] oZ2,
    output logic [DATA_W-1:0] oZ3
);

    localparam logic [DATA_W-1:0] IDLE_WORD = {DATA_W{IDLE_VAL}};

    logic [3:0] en;

    de_selector_14_dec uDec (
        .iS1 (iS1),
        .iS0 (iS0),
        .en  (en)
    );

    always_ff @(posedge iClk) begin
        if (iRst) oZ0 <= IDLE_WORD;
        else      oZ0 <= en[0] ? iC : IDLE_WORD;
    end

    always_ff @(posedge iClk) begin
        if (iRst) oZ1 <= IDLE_WORD;
        else      oZ1 <= en[1] ? iC : IDLE_WORD;
    end

    always_ff @(posedge iClk) begin
        if (iRst) oZ2 <= IDLE_WORD;
        else      oZ2 <= en[2] ? iC : IDLE_WORD;
    end

    always_ff @(posedge iClk) begin
        if (iRst) oZ3 <= IDLE_WORD;
        else      oZ3 <= en[3] ? iC : IDLE_WORD;
    end

endmodule

// File: tb/tb_de_selector_14.sv
// Bench for de_selector_14: directed sequence plus random steps against a channel-routing model.
module tb_de_selector_14;

    logic       clk = 1'b0;
    logic       rst;
    logic       c1;
    logic [3:0] c4;
    logic       s1, s0;

    logic       z1 [4];
    logic [3:0] z4 [4];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    de_selector_14 #(.DATA_W(1)) dut1 (
        .iClk (clk), .iRst (rst), .iC (c1), .iS1 (s1), .iS0 (s0),
        .oZ0 (z1[0]), .oZ1 (z1[1]), .oZ2 (z1[2]), .oZ3 (z1[3])
    );

    de_selector_14 #(.DATA_W(4), .IDLE_VAL(1'b1)) dut4 (
        .iClk (clk), .iRst (rst), .iC (c4), .iS1 (s1), .iS0 (s0),
        .oZ0 (z4[0]), .oZ1 (z4[1]), .oZ2 (z4[2]), .oZ3 (z4[3])
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, clock it, and compare all eight outputs to the routing rule.
    task automatic step(input logic r, input logic c, input logic [3:0] cw,
                        input int sel, input string tag);
        logic       e1;
        logic [3:0] e4;
        rst = r; c1 = c; c4 = cw;
        s1 = sel[1]; s0 = sel[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            e1 = (!r && k == sel) ? c  : 1'b1;
            e4 = (!r && k == sel) ? cw : 4'hF;
            check($sformatf("%s w1 oZ%0d", tag, k), {3'b000, z1[k]}, {3'b000, e1});
            check($sformatf("%s w4 oZ%0d", tag, k), z4[k], e4);
        end
    endtask

    // Outputs must not move between edges regardless of input/reset activity.
    task automatic holdCheck(input string tag);
        logic       h1 [4];
        logic [3:0] h4 [4];
        for (int k = 0; k < 4; k++) begin h1[k] = z1[k]; h4[k] = z4[k]; end
        rst = 1'b1; c1 = ~c1; c4 = ~c4; s1 = ~s1;
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s hold w1 oZ%0d", tag, k), {3'b000, z1[k]}, {3'b000, h1[k]});
            check($sformatf("%s hold w4 oZ%0d", tag, k), z4[k], h4[k]);
        end
    endtask

    initial begin
        rst = 1'b1; c1 = 1'b0; c4 = 4'h0; s1 = 1'b0; s0 = 1'b0;

        step(1'b1, 1'b0, 4'h0, 0, "reset0");
        step(1'b1, 1'b0, 4'h0, 0, "reset1");

        for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 4'h0, s, $sformatf("sweep0 sel%0d", s));
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 4'hF, s, $sformatf("sweep1 sel%0d", s));

        step(1'b0, 1'b0, 4'h0, 2, "midrst pre");
        holdCheck("midrst gap");
        step(1'b1, 1'b0, 4'h0, 2, "midrst on");
        step(1'b0, 1'b0, 4'h0, 2, "midrst post");

        for (int i = 0; i < 6; i++)
            step(1'b0, i[0], (i[0] ? 4'h5 : 4'hA), 1, $sformatf("toggle%0d", i));

        step(1'b0, 1'b0, 4'hA, 3, "wide A sel3");
        holdCheck("wide gap");

        for (int i = 0; i < 200; i++) begin
            logic       r;
            logic       c;
            logic [3:0] cw;
            int         sel;
            r   = ($urandom_range(0, 9) == 0);
            c   = 1'($urandom_range(0, 1));
            cw  = 4'($urandom_range(0, 15));
            sel = int'($urandom_range(0, 3));
            step(r, c, cw, sel, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
